// File: rtl/port_in.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | port_in : 8-bit synchronized, debounced input port with edge events / irq   |
// | Optional: define PORT_IN_IRQ_EN to build the EVENT/IRQ_EN/EDGE_SEL logic.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module port_in #(
  parameter int unsigned DEBOUNCE_CYCLES = 48000,
  parameter logic [7:0]  RESET_STATE     = 8'hFF
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] pins_in,
  input  logic [1:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       irq
);

  localparam int unsigned         c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] w_deb;
  logic [7:0] w_event;
  logic [7:0] w_irq_en;
  logic [7:0] w_edge_sel;
  logic [7:0] w_rd_mux;
  logic [7:0] r_rd_data;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_sync1 <= RESET_STATE;
      r_sync2 <= RESET_STATE;
    end else begin
      r_sync1 <= pins_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      logic               r_bit;
      logic [c_cnt_w-1:0] r_cnt;

      // The count tracks consecutive disagreeing samples; agreement restarts it.
      always_ff @(posedge clk_48mhz) begin
        if (reset) begin
          r_bit <= RESET_STATE[gi];
          r_cnt <= '0;
        end else if (r_sync2[gi] == r_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_bit <= r_sync2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end

      assign w_deb[gi] = r_bit;
    end
  endgenerate

`ifdef PORT_IN_IRQ_EN
  logic [7:0] r_deb_q;
  logic [7:0] r_event;
  logic [7:0] r_irq_en;
  logic [7:0] r_edge_sel;
  logic       r_irq;
  logic [7:0] w_set;
  logic [7:0] w_clr;

  always_comb begin
    w_set = ((w_deb & ~r_deb_q) & r_edge_sel) | ((~w_deb & r_deb_q) & ~r_edge_sel);
    w_clr = (wr && addr == 2'd1) ? wr_data : 8'h00;
  end

  // Set has priority over a same-cycle write-one-to-clear.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_deb_q    <= RESET_STATE;
      r_event    <= 8'h00;
      r_irq_en   <= 8'h00;
      r_edge_sel <= 8'h00;
      r_irq      <= 1'b0;
    end else begin
      r_deb_q <= w_deb;
      r_event <= (r_event & ~w_clr) | w_set;
      if (wr && addr == 2'd2) begin
        r_irq_en <= wr_data;
      end
      if (wr && addr == 2'd3) begin
        r_edge_sel <= wr_data;
      end
      r_irq <= |(r_event & r_irq_en);
    end
  end

  assign w_event    = r_event;
  assign w_irq_en   = r_irq_en;
  assign w_edge_sel = r_edge_sel;
  assign irq        = r_irq;
`else
  logic w_unused;

  assign w_unused   = ^{wr, wr_data};
  assign w_event    = 8'h00;
  assign w_irq_en   = 8'h00;
  assign w_edge_sel = 8'h00;
  assign irq        = 1'b0;
`endif

  always_comb begin
    w_rd_mux = 8'h00;
    case (addr)
      2'd0:    w_rd_mux = w_deb;
      2'd1:    w_rd_mux = w_event;
      2'd2:    w_rd_mux = w_irq_en;
      default: w_rd_mux = w_edge_sel;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else if (rd) begin
      r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_port_in.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_port_in : directed + randomized bench for port_in against a ref model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_port_in;

  localparam int unsigned DEB    = 4;
  localparam logic [7:0]  RST_ST = 8'hFF;
`ifdef PORT_IN_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pins;
  logic [1:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rd_data;
  logic       irq;

  always #5 clk = ~clk;

  port_in #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_STATE    (RST_ST)
  ) dut (
    .clk_48mhz(clk),
    .reset    (reset),
    .pins_in  (pins),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .wr_data  (wdata),
    .rd_data  (rd_data),
    .irq      (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pins reach the debouncer two samples late; a bit flips
  // once it has disagreed for DEB consecutive samples; edges land in EVENT
  // one sample after the flip.
  logic [7:0] pin_hist[$];
  logic [7:0] m_deb, m_evt, m_en, m_sel, m_rd, m_pend_rise, m_pend_fall;
  logic       m_irq;
  int         m_run[8];

  task automatic model_step(input logic r, input logic [7:0] p, input logic rdi,
                            input logic wri, input logic [1:0] a, input logic [7:0] d);
    logic [7:0] regv, clr, nd, sync, evt_n;
    if (r) begin
      pin_hist    = {RST_ST, RST_ST};
      m_deb       = RST_ST;
      m_evt       = 8'h00;
      m_en        = 8'h00;
      m_sel       = 8'h00;
      m_rd        = 8'h00;
      m_irq       = 1'b0;
      m_pend_rise = 8'h00;
      m_pend_fall = 8'h00;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      return;
    end
    case (a)
      2'd0:    regv = m_deb;
      2'd1:    regv = m_evt;
      2'd2:    regv = m_en;
      default: regv = m_sel;
    endcase
    if (rdi) m_rd = regv;
    m_irq = HAS_IRQ && ((m_evt & m_en) != 8'h00);
    clr   = (wri && a == 2'd1) ? d : 8'h00;
    evt_n = (m_evt & ~clr) | (m_pend_rise & m_sel) | (m_pend_fall & ~m_sel);
    m_evt = HAS_IRQ ? evt_n : 8'h00;
    if (HAS_IRQ && wri && a == 2'd2) m_en = d;
    if (HAS_IRQ && wri && a == 2'd3) m_sel = d;
    sync = pin_hist[0];
    nd   = m_deb;
    for (int i = 0; i < 8; i++) begin
      if (sync[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nd[i]    = sync[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pend_rise = nd & ~m_deb;
    m_pend_fall = ~nd & m_deb;
    m_deb       = nd;
    void'(pin_hist.pop_front());
    pin_hist.push_back(p);
  endtask

  task automatic tick(input logic r, input logic [7:0] p, input logic rdi,
                      input logic wri, input logic [1:0] a, input logic [7:0] d);
    reset = r;
    pins  = p;
    rd    = rdi;
    wr    = wri;
    addr  = a;
    wdata = d;
    @(posedge clk);
    model_step(r, p, rdi, wri, a, d);
    #1;
    check("rd_data", rd_data, m_rd);
    check("irq", {7'd0, irq}, {7'd0, m_irq});
  endtask

  logic [7:0] cur;

  task automatic step(input logic [7:0] p);
    cur = p;
    tick(1'b0, p, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic steps(input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) step(p);
  endtask

  task automatic rdreg(input logic [1:0] a);
    tick(1'b0, cur, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic wrreg(input logic [1:0] a, input logic [7:0] d);
    tick(1'b0, cur, 1'b0, 1'b1, a, d);
  endtask

  int lat;
  int budget;

  initial begin
    cur = RST_ST;
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1'b1, 8'hFF, 1'b1, 1'b1, 2'd2, 8'h55);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);
    rdreg(2'd0); check("reset_state", rd_data, 8'hFF);
    rdreg(2'd1); check("reset_event", rd_data, 8'h00);
    rdreg(2'd2); check("reset_irq_en", rd_data, 8'h00);
    rdreg(2'd3); check("reset_edge_sel", rd_data, 8'h00);

    // Debounce accept on bit 0
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(8'hFE);
      if (!rd_data[0] && lat == 0) lat = k;
    end
    check("deb_latency", lat[7:0], 8'd7);
    rdreg(2'd1); check("accept_event", rd_data, HAS_IRQ ? 8'h01 : 8'h00);

    // Release bit 0, clear event, then bounce bit 3
    steps(8'hFF, 10);
    wrreg(2'd1, 8'h01);
    for (int r = 0; r < 5; r++) begin
      steps(8'hF7, 3);
      steps(8'hFF, 1);
    end
    steps(8'hFF, 8);
    rdreg(2'd0); check("bounce_state", rd_data, 8'hFF);
    rdreg(2'd1); check("bounce_event", rd_data, 8'h00);

    // Interrupt and W1C race
    wrreg(2'd2, 8'h01);
    steps(8'hFE, 12);
    check("irq_set", {7'd0, irq}, {7'd0, HAS_IRQ});
    steps(8'hFF, 10);
    budget = 0;
    cur = 8'hFE;
    do begin
      step(8'hFE);
      budget++;
    end while (!m_pend_fall[0] && budget < 30);
    check("race_setup", {7'd0, m_pend_fall[0]}, 8'h01);
    wrreg(2'd1, 8'h01);
    check("race_irq", {7'd0, irq}, {7'd0, HAS_IRQ});
    rdreg(2'd1); check("race_event", rd_data, HAS_IRQ ? 8'h01 : 8'h00);
    check("race_irq_hold", {7'd0, irq}, {7'd0, HAS_IRQ});
    wrreg(2'd1, 8'h01);
    check("w1c_irq_n1", {7'd0, irq}, {7'd0, HAS_IRQ});
    rdreg(2'd0);
    check("w1c_irq_n2", {7'd0, irq}, 8'h00);

    // Edge select: only rising edge of bit 7 counts
    steps(8'hFF, 10);
    wrreg(2'd3, 8'h80);
    wrreg(2'd1, 8'hFF);
    steps(8'h7F, 10);
    steps(8'hFF, 10);
    rdreg(2'd1); check("edge_sel_event", rd_data, HAS_IRQ ? 8'h80 : 8'h00);
    rdreg(2'd3); check("edge_sel_reg", rd_data, HAS_IRQ ? 8'h80 : 8'h00);

    // Randomized traffic checked against the model every cycle
    for (int n = 0; n < 400; n++) begin
      logic [7:0] p;
      int hold;
      p    = cur ^ 8'($urandom & $urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        logic       rr, ww, rs;
        logic [1:0] aa;
        rs = ($urandom_range(0, 499) == 0);
        rr = $urandom_range(0, 1) == 1;
        ww = $urandom_range(0, 3) == 0;
        aa = 2'($urandom_range(0, 3));
        cur = p;
        tick(rs, p, rr, ww, aa, 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/port_in.md
# port_in

Eight-bit debounced input port for the Schoko SoC, the input-direction counterpart to the `port_a` LED output port. It samples eight external pins (PMOD switches or buttons), synchronizes and debounces them, and latches configurable edge events. The SoC reads it through a simple 2-bit-addressed register bus and can take an optional interrupt.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 48000: consecutive stable synchronized samples before a debounced bit changes (1 ms at 48 MHz). Legal range is ≥1.
- `RESET_STATE`, default 8'hFF: debounced state after reset; pins idle high.

Ports:
- `clk_48mhz`, input, 1: sole clock. Everything is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `pins_in`, input, 8: raw asynchronous external pins.
- `addr`, input, 2: register select.
- `rd`, input, 1: read strobe, one cycle.
- `wr`, input, 1: write strobe, one cycle.
- `wr_data`, input, 8: write data.
- `rd_data`, output, 8: registered read data.
- `irq`, output, 1: level interrupt, active high.

## Operation

- **Synchronizer:** two flops per bit. They reset to `RESET_STATE`.
- **Debounce, per bit:**
  - Each bit has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When the synced bit equals the debounced bit, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the bit still differs, the debounced bit takes the synced value and the counter clears.
  - Any return to agreement before then clears the counter with no change.
  - The counter never wraps.
- **Registers:**
  - addr 0, STATE (RO): debounced bits. Writes are ignored.
  - addr 1, EVENT (R/W1C): sticky edge flags. Writing a 1 clears that bit.
  - addr 2, IRQ_EN (R/W): per-bit interrupt mask. Resets to 8'h00.
  - addr 3, EDGE_SEL (R/W): per bit, 1 = rising edge and 0 = falling edge of the debounced bit. Resets to 8'h00 (falling, matching active-low buttons).
- **Event set:** the debounced bit changes in the direction selected by EDGE_SEL.
- **Simultaneous W1C and new event on the same bit:** the set wins and the bit stays 1.
- **EDGE_SEL changes:** take effect for subsequent transitions only. Existing EVENT bits are not re-evaluated.
- **irq:** `|(EVENT & IRQ_EN)`, registered.
- **rd and wr in the same cycle:** the write is performed and the read returns the pre-write value.
- **Out-of-scope bus activity:** `rd`/`wr` are ignored during `reset`.
- **Reset values:**
  - `rd_data` = 0, `irq` = 0, EVENT = 0.
  - Debounced state = `RESET_STATE`, counters = 0.
  - Reset mid-debounce discards the partial count.

## Timing

- Pin to debounced state: 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles of stability.
- Debounced change to EVENT bit set: 1 cycle.
- EVENT set to `irq` high: 1 cycle.
- `rd` at cycle N: `rd_data` is valid at N+1 and holds until the next `rd`.
- W1C `wr` at cycle N: the EVENT bit is clear at N+1 and `irq` drops at N+2, unless another event was set.
- There is no back-pressure. Strobes are single-cycle and may be issued every cycle.

## Configuration

- `PORT_IN_IRQ_EN` defined:
  - EVENT, IRQ_EN and EDGE_SEL registers and `irq` are implemented as described.
- Not defined:
  - Edge and interrupt logic is compiled out.
  - Addresses 1–3 read 8'h00 and writes to them are ignored.
  - `irq` is tied to 0.
  - STATE and debounce are unchanged.

## Test plan

- **Reset:** assert `reset` for 2 cycles with pins = 8'hFF, then read addr 0.
  - `rd_data` = 8'hFF, `irq` = 0.
  - Addrs 1/2/3 read 8'h00.
- **Debounce accept:** with `DEBOUNCE_CYCLES`=4, drive `pins_in[0]` low and hold it.
  - STATE[0] reads 0 exactly 2+4 cycles later.
  - EVENT[0] = 1 one cycle after that.
- **Bounce reject:** with `DEBOUNCE_CYCLES`=4, toggle `pins_in[3]` low for 3 cycles, high for 1, repeated 5 times.
  - STATE stays 8'hFF and EVENT stays 0.
- **Interrupt with W1C race:**
  - Set IRQ_EN = 8'h01 and produce a bit-0 falling event: `irq` = 1.
  - Write 8'h01 to addr 1 in the same cycle as a new bit-0 falling event: EVENT[0] stays 1 and `irq` stays 1.
  - A later W1C drops `irq` 2 cycles after the write.
- **Edge select:** set EDGE_SEL = 8'h80 and drive bit 7 low then high, each held stable.
  - Only the rising edge sets EVENT[7]; EVENT reads 8'h80.
- **Macro off:** build without `PORT_IN_IRQ_EN` and repeat the interrupt test.
  - `irq` stays 0 and addr 1 reads 8'h00.
  - STATE tracks pins as in the debounce-accept test.
